// File: rtl/axi4_tlp_tag_router_pkg.sv
// Shared definitions for the TLP tag router.
// Contents: router FSM state encoding, AXI-Stream beat widths shared with the
// upstream straddle convertor, and RC descriptor field offsets.
package axi4_tlp_tag_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int AXIS_TDATA_W = 512;
  localparam int AXIS_TKEEP_W = 16;
  // TUSER width produced by the straddle convertor.
  localparam int AXI_TUSER_W  = 161;

  // RC descriptor fields (dword 2 carries the tag in bits 71:64).
  localparam int RC_TAG_LSB   = 64;
  localparam int RC_TAG_W     = 8;
  // The route field is taken from the upper tag bits.
  localparam int RC_ROUTE_LSB = 70;
  localparam int RC_ERR_LSB   = 12;
  localparam int RC_ERR_W     = 4;

  localparam int DROP_CNT_W   = 16;

endpackage

// File: rtl/axi4_tlp_tag_router_slice.sv
// Single-entry valid/ready holding register (AXI-Stream register slice).
// One cycle of latency; accepts a new beat in the same cycle the held beat
// drains, so it sustains one beat per cycle.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset (valid only)
//   s_valid_i/s_ready_o  upstream handshake, s_data_i upstream payload
//   m_valid_o/m_ready_i  downstream handshake, m_data_o held payload
module axis_reg_slice
  import axi4_tlp_tag_router_pkg::*;
#(
  parameter int W = AXIS_TDATA_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic         load;

  // Empty, or the held beat leaves this cycle.
  assign s_ready_o = !valid_q || m_ready_i;
  assign load      = s_valid_i && s_ready_o;

  always_comb begin
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload carries no reset; it is only observed qualified by valid.
  always_ff @(posedge clk_i) begin
    if (load) begin
      data_q <= s_data_i;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

endmodule

// File: rtl/axi4_tlp_tag_router.sv
// Routes whole de-straddled TLPs to one of NUM_PORTS master streams, chosen
// by the route field in the first-beat descriptor. TLPs aimed at disabled
// ports are swallowed and counted. Output is registered (1-cycle latency).
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   PORT_EN           per-port enable, sampled on the first beat of a TLP
//   S_AXIS_*          slave stream (TUSER/TDATA/TKEEP/TLAST/TVALID/TREADY)
//   M_AXIS_*          flattened per-port master streams, port 0 in the LSBs
//   DROP_COUNT        saturating count of dropped TLPs
module axi4_tlp_tag_router
  import axi4_tlp_tag_router_pkg::*;
#(
  parameter int AXI_TUSER_L = AXI_TUSER_W,
  parameter int NUM_PORTS   = 4,
  parameter int ROUTE_LSB   = RC_ROUTE_LSB
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [NUM_PORTS-1:0]                 PORT_EN,
  input  logic [AXI_TUSER_L-1:0]               S_AXIS_TUSER,
  input  logic [AXIS_TDATA_W-1:0]              S_AXIS_TDATA,
  input  logic [AXIS_TKEEP_W-1:0]              S_AXIS_TKEEP,
  input  logic                                 S_AXIS_TLAST,
  input  logic                                 S_AXIS_TVALID,
  output logic                                 S_AXIS_TREADY,
  output logic [NUM_PORTS*AXI_TUSER_L-1:0]     M_AXIS_TUSER,
  output logic [NUM_PORTS*AXIS_TDATA_W-1:0]    M_AXIS_TDATA,
  output logic [NUM_PORTS*AXIS_TKEEP_W-1:0]    M_AXIS_TKEEP,
  output logic [NUM_PORTS-1:0]                 M_AXIS_TLAST,
  output logic [NUM_PORTS-1:0]                 M_AXIS_TVALID,
  input  logic [NUM_PORTS-1:0]                 M_AXIS_TREADY,
  output logic [DROP_CNT_W-1:0]                DROP_COUNT
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int BEAT_W = AXIS_TDATA_W + AXIS_TKEEP_W + AXI_TUSER_L + 1;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_e                  state_q, state_d;
  logic [PORT_W-1:0]       sel_q, sel_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PORT_W-1:0]       route;
  logic                    slv_hs;
  logic                    fwd_beat;
  logic                    rs_ready;
  logic                    out_valid;
  logic [BEAT_W-1:0]       beat_in;
  logic [BEAT_W-1:0]       beat_out;
  logic [AXIS_TDATA_W-1:0] out_data;
  logic [AXIS_TKEEP_W-1:0] out_keep;
  logic [AXI_TUSER_L-1:0]  out_user;
  logic                    out_last;

  assign route = S_AXIS_TDATA[ROUTE_LSB +: PORT_W];

  // rs_ready is "holding register empty or draining on port sel_q". Using it
  // for first beats too means sel can only move once the old beat has left,
  // so a held beat is never re-presented on a different port.
  assign S_AXIS_TREADY = !ARESET && ((state_q == ST_DROP) || rs_ready);
  assign slv_hs        = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    drop_cnt_d = drop_cnt_q;
    fwd_beat   = 1'b0;
    if (slv_hs) begin
      case (state_q)
        ST_IDLE: begin
          if (PORT_EN[route]) begin
            sel_d    = route;
            fwd_beat = 1'b1;
            state_d  = S_AXIS_TLAST ? ST_IDLE : ST_FWD;
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = S_AXIS_TLAST ? ST_IDLE : ST_DROP;
          end
        end
        ST_FWD: begin
          fwd_beat = 1'b1;
          if (S_AXIS_TLAST) state_d = ST_IDLE;
        end
        ST_DROP: begin
          if (S_AXIS_TLAST) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_COUNT = drop_cnt_q;

  // Stage boundary: routed beat enters the shared holding register.
  assign beat_in = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TKEEP, S_AXIS_TDATA};

  axis_reg_slice #(
    .W (BEAT_W)
  ) u_slice (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .s_valid_i (fwd_beat),
    .s_ready_o (rs_ready),
    .s_data_i  (beat_in),
    .m_valid_o (out_valid),
    .m_ready_i (M_AXIS_TREADY[sel_q]),
    .m_data_o  (beat_out)
  );

  assign {out_last, out_user, out_keep, out_data} = beat_out;

  // Demux: only port sel_q sees the register; every other port drives zeros.
  always_comb begin
    M_AXIS_TVALID = '0;
    M_AXIS_TLAST  = '0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TUSER  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_q == PORT_W'(p)) begin
        M_AXIS_TVALID[p]                              = out_valid;
        M_AXIS_TLAST[p]                               = out_last;
        M_AXIS_TDATA[p*AXIS_TDATA_W +: AXIS_TDATA_W]  = out_data;
        M_AXIS_TKEEP[p*AXIS_TKEEP_W +: AXIS_TKEEP_W]  = out_keep;
        M_AXIS_TUSER[p*AXI_TUSER_L +: AXI_TUSER_L]    = out_user;
      end
    end
  end

endmodule

// File: tb/tb_axi4_tlp_tag_router.sv
// Scoreboard bench for axi4_tlp_tag_router: stimulus pushes expected beats,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axi4_tlp_tag_router;

  localparam int NP    = 4;
  localparam int UW    = 161;
  localparam int RLSB  = 70;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic [NP-1:0]      PORT_EN;
  logic [UW-1:0]      S_AXIS_TUSER;
  logic [511:0]       S_AXIS_TDATA;
  logic [15:0]        S_AXIS_TKEEP;
  logic               S_AXIS_TLAST;
  logic               S_AXIS_TVALID;
  logic               S_AXIS_TREADY;
  logic [NP*UW-1:0]   M_AXIS_TUSER;
  logic [NP*512-1:0]  M_AXIS_TDATA;
  logic [NP*16-1:0]   M_AXIS_TKEEP;
  logic [NP-1:0]      M_AXIS_TLAST;
  logic [NP-1:0]      M_AXIS_TVALID;
  logic [NP-1:0]      M_AXIS_TREADY;
  logic [15:0]        DROP_COUNT;

  axi4_tlp_tag_router #(
    .AXI_TUSER_L (UW),
    .NUM_PORTS   (NP),
    .ROUTE_LSB   (RLSB)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .PORT_EN       (PORT_EN),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TKEEP  (S_AXIS_TKEEP),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .DROP_COUNT    (DROP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int           port;
    logic [511:0] data;
    logic [15:0]  keep;
    logic [UW-1:0] user;
    logic         last;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   id     = 0;
  int   stalls = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one beat; wait (bounded) for the handshake; queue its expectation.
  // exp_port < 0 means the beat must be swallowed.
  task automatic send(input int route, input logic last, input int exp_port);
    logic [511:0]  d;
    logic [31:0]   idv;
    logic [15:0]   k;
    logic [UW-1:0] u;
    exp_t          e;
    int            waited;
    bit            ok;
    idv = 32'(id);
    id++;
    d = {16{32'hC0DE0000 ^ idv}};
    d[RLSB +: 2] = 2'(route);
    k = 16'hFFFF >> idv[1:0];
    u = {1'b1, {5{32'hB0000000 | idv}}};
    S_AXIS_TDATA  = d;
    S_AXIS_TKEEP  = k;
    S_AXIS_TUSER  = u;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited <= 200) begin
      @(negedge ACLK);
      if (S_AXIS_TREADY) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check("s_ready_timeout", {511'b0, S_AXIS_TREADY}, 512'd1);
      S_AXIS_TVALID = 1'b0;
    end else begin
      stalls += waited;
      if (exp_port >= 0) begin
        e.port = exp_port; e.data = d; e.keep = k; e.user = u; e.last = last;
        q.push_back(e);
      end
      @(posedge ACLK);
      #1;
      S_AXIS_TVALID = 1'b0;
    end
  endtask

  // Monitor.
  int            nv, vp;
  bit            hold_pending = 1'b0;
  logic [511:0]  held_data;
  logic [UW-1:0] held_user;
  exp_t          me;

  always @(negedge ACLK) begin
    nv = 0;
    vp = 0;
    for (int p = 0; p < NP; p++) begin
      if (M_AXIS_TVALID[p]) begin
        nv++;
        vp = p;
      end
    end
    if (hold_pending) begin
      check("hold_valid_count", 512'(nv), 512'd1);
      check("hold_data", M_AXIS_TDATA[vp*512 +: 512], held_data);
      check("hold_user", 512'(M_AXIS_TUSER[vp*UW +: UW]), 512'(held_user));
    end
    hold_pending = 1'b0;
    if (nv > 1) begin
      check("one_hot_valid", 512'(M_AXIS_TVALID), 512'(1 << vp));
    end else if (nv == 1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 512'(M_AXIS_TVALID), 512'd0);
      end else begin
        me = q[0];
        check("out_port", 512'(vp), 512'(me.port));
        for (int p = 0; p < NP; p++) begin
          if (p != vp) check("idle_port_data", M_AXIS_TDATA[p*512 +: 512], 512'd0);
        end
        if (M_AXIS_TREADY[vp]) begin
          check("out_data", M_AXIS_TDATA[vp*512 +: 512], me.data);
          check("out_keep", 512'(M_AXIS_TKEEP[vp*16 +: 16]), 512'(me.keep));
          check("out_user", 512'(M_AXIS_TUSER[vp*UW +: UW]), 512'(me.user));
          check("out_last", 512'(M_AXIS_TLAST[vp]), 512'(me.last));
          void'(q.pop_front());
        end else begin
          hold_pending = 1'b1;
          held_data    = M_AXIS_TDATA[vp*512 +: 512];
          held_user    = M_AXIS_TUSER[vp*UW +: UW];
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    ARESET        = 1'b1;
    PORT_EN       = 4'b1111;
    M_AXIS_TREADY = 4'b1111;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TKEEP  = '0;
    S_AXIS_TUSER  = '0;
    S_AXIS_TLAST  = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_s_ready", 512'(S_AXIS_TREADY), 512'd0);
    check("rst_m_valid", 512'(M_AXIS_TVALID), 512'd0);
    check("rst_drop_count", 512'(DROP_COUNT), 512'd0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;

    // 3-beat TLP to port 2; PORT_EN change mid-TLP must not matter.
    send(2, 1'b0, 2);
    check("t1_latency_valid", 512'(M_AXIS_TVALID), 512'b0100);
    PORT_EN = 4'b1011;
    send(1, 1'b0, 2);
    send(0, 1'b1, 2);
    PORT_EN = 4'b1111;
    check("t1_drop_count", 512'(DROP_COUNT), 512'd0);

    // Back-to-back single-beat TLPs, no stalls expected.
    stalls = 0;
    send(0, 1'b1, 0);
    send(1, 1'b1, 1);
    send(3, 1'b1, 3);
    send(0, 1'b1, 0);
    check("t2_no_stall", 512'(stalls), 512'd0);

    // Drop a 4-beat TLP to disabled port 2, then forward to port 1.
    PORT_EN = 4'b1011;
    send(2, 1'b0, -1);
    PORT_EN = 4'b1111;
    send(2, 1'b0, -1);
    send(0, 1'b0, -1);
    send(1, 1'b1, -1);
    check("t3_drop_count", 512'(DROP_COUNT), 512'd1);
    send(1, 1'b0, 1);
    send(2, 1'b1, 1);

    // Port 0 backpressure for 5 cycles during a 4-beat TLP.
    stalls = 0;
    M_AXIS_TREADY[0] = 1'b0;
    fork
      begin
        send(0, 1'b0, 0);
        send(3, 1'b0, 0);
        send(2, 1'b0, 0);
        send(1, 1'b1, 0);
      end
      begin
        repeat (5) @(posedge ACLK);
        #1 M_AXIS_TREADY[0] = 1'b1;
      end
    join
    check("t4_s_ready_fell", 512'(stalls > 0), 512'd1);

    // Saturation: 65537 dropped single-beat TLPs on top of the count of 1.
    PORT_EN = 4'b0000;
    for (int i = 0; i < 65533; i++) send(i & 3, 1'b1, -1);
    check("t5_count_fffe", 512'(DROP_COUNT), 512'hFFFE);
    send(1, 1'b1, -1);
    check("t5_count_ffff", 512'(DROP_COUNT), 512'hFFFF);
    send(2, 1'b1, -1);
    send(3, 1'b1, -1);
    send(0, 1'b1, -1);
    check("t5_count_no_wrap", 512'(DROP_COUNT), 512'hFFFF);
    PORT_EN = 4'b1111;

    // Reset during beat 2 of a 4-beat TLP to port 1.
    send(1, 1'b0, 1);
    send(0, 1'b0, 1);
    S_AXIS_TDATA[RLSB +: 2] = 2'd3;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b1;
    ARESET        = 1'b1;
    @(negedge ACLK);
    check("t6_rst_s_ready", 512'(S_AXIS_TREADY), 512'd0);
    @(posedge ACLK);
    #1;
    ARESET        = 1'b0;
    S_AXIS_TVALID = 1'b0;
    check("t6_m_valid", 512'(M_AXIS_TVALID), 512'd0);
    check("t6_drop_count", 512'(DROP_COUNT), 512'd0);
    // Remaining beats form a new TLP routed by beat 2's field (port 3).
    send(3, 1'b0, 3);
    send(2, 1'b1, 3);

    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(posedge ACLK);
      w++;
    end
    check("scoreboard_drained", 512'(q.size()), 512'd0);
    repeat (2) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
